// File: rtl/demod_uart_tx_pkg.sv
// rtl/demod_uart_tx_pkg.sv - shared frame geometry and serializer state encoding
package demod_uart_tx_pkg;

   localparam int FRAME_W         = 40;
   localparam int BYTES_PER_FRAME = 5;
   localparam int UART_BITS       = 10;
   localparam int DATA_BITS       = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } uart_state_t;

endpackage

// File: rtl/demod_uart_tx_fifo.sv
// rtl/demod_uart_tx_fifo.sv - DEPTH x WIDTH register FIFO holding whole frames
module frame_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 40
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign level    = wr_ptr - rd_ptr;
   assign full     = (level == (AW+1)'(DEPTH));
   assign empty    = (level == '0);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/demod_uart_tx.sv
// rtl/demod_uart_tx.sv - queues validated demodulator frames and sends them as 5 UART bytes each
module demod_uart_tx
   import demod_uart_tx_pkg::*;
#(
   parameter int CLK_DIV = 52,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [FRAME_W-1:0]       para_in,
   input  logic                     para_valid,
   output logic                     tx,
   output logic                     tx_busy,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
   localparam logic [2:0]    LAST_BYTE = 3'(BYTES_PER_FRAME - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

   uart_state_t        state;
   logic [BW-1:0]      baud_cnt;
   logic [2:0]         bit_idx;
   logic [2:0]         byte_idx;
   logic [FRAME_W-1:0] shreg;
   logic [7:0]         cur_byte;

   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   logic               drop;
   logic               has_frame;
   logic               bit_end;
   logic [FRAME_W-1:0] pop_data;

   // A full FIFO still accepts a frame when the serializer drains one in the same cycle.
   assign pop       = (state == ST_LOAD);
   assign push      = para_valid && (!fifo_full || pop);
   assign drop      = para_valid && !push;
   assign has_frame = !fifo_empty || push;
   assign bit_end   = (baud_cnt == BAUD_LAST);
   assign cur_byte  = shreg[FRAME_W-1 -: 8];

   frame_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (FRAME_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (para_in),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   // tx is set on the same edge that enters each state, so the line is purely registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               baud_cnt <= '0;
               tx       <= 1'b1;
               if (has_frame) begin
                  state   <= ST_LOAD;
                  tx_busy <= 1'b1;
               end
            end
            ST_LOAD: begin
               shreg    <= pop_data;
               byte_idx <= '0;
               baud_cnt <= '0;
               tx       <= 1'b0;
               state    <= ST_START;
            end
            ST_START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= cur_byte[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == LAST_BIT) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (byte_idx != LAST_BYTE) begin
                     byte_idx <= byte_idx + 3'd1;
                     shreg    <= shreg << 8;
                     tx       <= 1'b0;
                     state    <= ST_START;
                  end else if (has_frame) begin
                     tx    <= 1'b1;
                     state <= ST_LOAD;
                  end else begin
                     tx      <= 1'b1;
                     tx_busy <= 1'b0;
                     state   <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BW'(1);
               end
            end
            default: begin
               tx      <= 1'b1;
               tx_busy <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
